sqrt_fp_iter: RTL and testbench
===============================

Name: sqrt_fp_iter

Overview:
- Parametrised iterative IEEE-754 square root. Exponent and mantissa widths are generic, so it covers fp16/fp32/bfloat16.
- The mantissa uses a restoring digit-by-digit integer square root, one result bit per clock, with round-to-nearest.
- Valid/ready handshakes on both sides. Handles special operands and reports invalid/inexact flags.
- Sits in the PE datapath beside the divide/mean units and replaces the divide-and-average approximation loop with a fixed-latency, exact-rounded unit.

Parameters:
- EXP_W, 8, exponent field width (≥3).
- MAN_W, 23, stored fraction width (≥2).
- Derived: W = EXP_W+MAN_W+1; BIAS = 2^(EXP_W-1)-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand present.
- in_ready  out  1  unit can accept an operand.
- in_a  in  W  operand {sign, exp, frac}.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- out_sqrt  out  W  result.
- out_invalid  out  1  invalid-operation flag for this result.
- out_inexact  out  1  result was rounded, or the remainder was nonzero.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; out_valid=0; out_sqrt=0; out_invalid=0; out_inexact=0.
  - All iteration registers are cleared. in_ready=1 once rst deasserts.
  - A reset mid-operation discards the operation; no partial result is ever presented.
- States: IDLE, CALC, ROUND, DONE.
- in_ready = (state==IDLE). An operand is accepted on a rising edge with in_valid & in_ready.
- Classification at accept (E = exp field, F = frac):
  - E==0 (zero or denormal): result {sign,0...0}, flags 0. Denormals are flushed and sign is kept, so -0 → -0.
  - E==all-ones, F!=0 (NaN): canonical qNaN {0, all-ones, 1, 0...0}, invalid=0.
  - sign=1, E!=0, not NaN: canonical qNaN, invalid=1.
  - +inf: +inf, flags 0.
  - For all special cases: IDLE→DONE; out_valid is high after the accepting edge (latency 1).
- Normal operand path:
  - e = E-BIAS, signed EXP_W+1 bits; odd = e[0].
  - Result exponent = (e>>>1)+BIAS (arithmetic shift).
  - Radicand X = {1,F} << (MAN_W+2+odd), width 2*MAN_W+4.
  - IDLE→CALC; iteration counter loaded with MAN_W+2.
- CALC:
  - Each edge runs one restoring step: remainder = (rem<<2)|next two radicand bits; trial = (root<<2)|1.
  - If remainder ≥ trial: subtract and shift in a 1. Otherwise shift in a 0.
  - The counter decrements; at 0 go to ROUND. The root Q (MAN_W+2 bits: hidden, frac, guard) is in [2^(MAN_W+1), 2^(MAN_W+2)).
- ROUND:
  - mant = Q[MAN_W+1:1] + Q[0]. Round-half-up equals RNE here because sqrt ties are impossible.
  - If the carry reaches 2^(MAN_W+1): exponent+1, frac=0.
  - inexact = Q[0] | (rem!=0).
  - Output registers are written; go to DONE.
- Normal latency: out_valid is high after edge MAN_W+3 counted from the accepting edge (edge 0). fp32 = edge 26, fp16 = edge 13.
- DONE:
  - out_valid=1. out_sqrt and flags are held stable while out_ready=0, with unbounded backpressure.
  - An edge with out_ready=1 → IDLE and out_valid=0.
  - No same-edge accept: the next operand is accepted at the earliest one edge later.
- in_a changes while not accepted are ignored; the operand is captured only at accept.

Decomposition:
- Shared package fp_pkg holds:
  - default EXP_W/MAN_W;
  - a BIAS function;
  - a canonical qNaN constructor function;
  - the state enum {IDLE, CALC, ROUND, DONE};
  - classification constants.
- One sub-module, isqrt_step: a combinational single restoring iteration.
  - Inputs: rem, root, two radicand bits.
  - Outputs: next rem, next root.
  - Parametrised by MAN_W.
  - Top level holds the FSM, counter, classification and rounding.

Test Plan:
- fp32 0x40800000 (4.0) → 0x40000000, inexact 0, out_valid first high after edge 26. Also 0x3E800000 (0.25) → 0x3F000000.
- fp32 0x40000000 (2.0) → 0x3FB504F3, inexact 1, invalid 0.
- Specials, 1-cycle latency:
  - 0xC0800000 → 0x7FC00000, invalid 1.
  - 0x80000000 → 0x80000000.
  - 0x7F800000 → 0x7F800000.
  - 0x00000001 → 0x00000000.
  - 0x7F800001 → 0x7FC00000, invalid 0.
- Backpressure: hold out_ready=0 for 10 cycles after 2.0 completes → out_sqrt stable at 0x3FB504F3 and in_ready=0 throughout. Raise out_ready → IDLE on the next edge; the next operand is accepted one edge later.
- Reset at CALC iteration 10 → out_valid=0, flags 0 immediately. After rst deasserts, in_ready=1, and a fresh 4.0 produces 0x40000000 with nominal latency.
- Instance EXP_W=5, MAN_W=10: 0x4880 (9.0) → 0x4200, inexact 0, out_valid after edge 13. 0x4400 (4.0) → 0x4000.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point types, constants and helpers
package fp_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ROUND,
    DONE
  } state_e;

  // Operand classes resolved at accept time
  typedef enum logic [2:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_NAN,
    CLS_NEG,
    CLS_INF
  } fp_class_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN {0, all-ones, 1, 0...0}, right-aligned in 64 bits
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = '0;
    r[man_w-1] = 1'b1;
    for (int i = 0; i < exp_w; i++) begin
      r[man_w+i] = 1'b1;
    end
    return r;
  endfunction

  // Zero/denormal wins over sign so that -0 and negative denormals stay signed zeros
  function automatic fp_class_e fp_classify(input logic sign, input logic exp_zero,
                                            input logic exp_ones, input logic frac_zero);
    if (exp_zero)
      return CLS_ZERO;
    else if (exp_ones && !frac_zero)
      return CLS_NAN;
    else if (sign)
      return CLS_NEG;
    else if (exp_ones)
      return CLS_INF;
    else
      return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// rtl/isqrt_step.sv - one restoring digit-by-digit integer square root iteration
module isqrt_step #(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W+4:0] rem_i,
  input  logic [MAN_W+1:0] root_i,
  input  logic [1:0]       bits_i,
  output logic [MAN_W+4:0] rem_o,
  output logic [MAN_W+1:0] root_o
);

  localparam int REM_W  = MAN_W + 5;
  localparam int ROOT_W = MAN_W + 2;

  logic [REM_W-1:0] rem_sh;
  logic [REM_W-1:0] trial;
  logic             take;

  // Bring down two radicand bits and try to subtract (4*root + 1)
  always_comb begin
    rem_sh = (rem_i << 2) | REM_W'(bits_i);
    trial  = {1'b0, root_i, 2'b01};
    take   = (rem_sh >= trial);
    rem_o  = take ? (rem_sh - trial) : rem_sh;
    root_o = (root_i << 1) | ROOT_W'(take);
  end

endmodule

// File: rtl/sqrt_fp_iter.sv
// rtl/sqrt_fp_iter.sv - iterative IEEE-754 square root, one root bit per clock
module sqrt_fp_iter
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_sqrt,
  output logic                     out_invalid,
  output logic                     out_inexact
);

  localparam int W      = EXP_W + MAN_W + 1;
  localparam int BIAS   = fp_bias(EXP_W);
  localparam int RAD_W  = 2 * MAN_W + 4;
  localparam int REM_W  = MAN_W + 5;
  localparam int ROOT_W = MAN_W + 2;
  localparam int CNT_W  = $clog2(MAN_W + 3);

  localparam logic [W-1:0]     QNAN     = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [EXP_W:0]   BIAS_V   = (EXP_W + 1)'(BIAS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MAN_W + 2);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RAD_W-1:0]  rad_q, rad_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [W-1:0]      out_sqrt_q, out_sqrt_d;
  logic              out_invalid_q, out_invalid_d;
  logic              out_inexact_q, out_inexact_d;

  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MAN_W-1:0]  in_frac;
  fp_class_e         in_cls;
  logic [EXP_W:0]    exp_sum;
  logic              exp_odd;
  logic [RAD_W-1:0]  rad_init;

  logic [REM_W-1:0]  step_rem;
  logic [ROOT_W-1:0] step_root;

  logic [MAN_W:0]    mant_r;
  logic              mant_carry;
  logic [EXP_W-1:0]  exp_rnd;
  logic [W-1:0]      rnd_word;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_sqrt    = out_sqrt_q;
  assign out_invalid = out_invalid_q;
  assign out_inexact = out_inexact_q;

  // Field split, classification and radicand alignment of the incoming operand.
  // (E + BIAS) has the parity of the unbiased exponent, and half of it is the
  // biased result exponent, so one adder yields both.
  always_comb begin
    in_sign  = in_a[W-1];
    in_exp   = in_a[W-2:MAN_W];
    in_frac  = in_a[MAN_W-1:0];
    in_cls   = fp_classify(in_sign, (in_exp == '0), (in_exp == '1), (in_frac == '0));
    exp_sum  = {1'b0, in_exp} + BIAS_V;
    exp_odd  = exp_sum[0];
    rad_init = exp_odd ? (RAD_W'({1'b1, in_frac}) << (MAN_W + 3))
                       : (RAD_W'({1'b1, in_frac}) << (MAN_W + 2));
  end

  isqrt_step #(
    .MAN_W (MAN_W)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[RAD_W-1 -: 2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  // Round half-up on the guard bit; a wrap of the hidden bit means the
  // mantissa reached 2.0 and the exponent bumps with a zero fraction
  always_comb begin
    mant_r     = root_q[MAN_W+1:1] + (MAN_W + 1)'(root_q[0]);
    mant_carry = root_q[MAN_W+1] & ~mant_r[MAN_W];
    exp_rnd    = exp_q + EXP_W'(mant_carry);
    rnd_word   = {1'b0, exp_rnd, mant_r[MAN_W-1:0]};
  end

  // Next-state and datapath updates for the sequencer
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rad_d         = rad_q;
    rem_d         = rem_q;
    root_d        = root_q;
    exp_d         = exp_q;
    out_sqrt_d    = out_sqrt_q;
    out_invalid_d = out_invalid_q;
    out_inexact_d = out_inexact_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          out_invalid_d = 1'b0;
          out_inexact_d = 1'b0;
          state_d       = DONE;
          case (in_cls)
            CLS_ZERO: out_sqrt_d = {in_sign, {(W - 1){1'b0}}};
            CLS_NAN:  out_sqrt_d = QNAN;
            CLS_NEG: begin
              out_sqrt_d    = QNAN;
              out_invalid_d = 1'b1;
            end
            CLS_INF:  out_sqrt_d = in_a;
            default: begin
              out_invalid_d = out_invalid_q;
              out_inexact_d = out_inexact_q;
              exp_d         = exp_sum[EXP_W:1];
              rad_d         = rad_init;
              rem_d         = '0;
              root_d        = '0;
              cnt_d         = CNT_INIT;
              state_d       = CALC;
            end
          endcase
        end
      end
      CALC: begin
        rem_d  = step_rem;
        root_d = step_root;
        rad_d  = rad_q << 2;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1))
          state_d = ROUND;
      end
      ROUND: begin
        out_sqrt_d    = rnd_word;
        out_invalid_d = 1'b0;
        out_inexact_d = root_q[0] | (rem_q != '0);
        state_d       = DONE;
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rad_q         <= '0;
      rem_q         <= '0;
      root_q        <= '0;
      exp_q         <= '0;
      out_sqrt_q    <= '0;
      out_invalid_q <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rad_q         <= rad_d;
      rem_q         <= rem_d;
      root_q        <= root_d;
      exp_q         <= exp_d;
      out_sqrt_q    <= out_sqrt_d;
      out_invalid_q <= out_invalid_d;
      out_inexact_q <= out_inexact_d;
    end
  end

endmodule

// File: tb/tb_sqrt_fp_iter.sv
// tb/tb_sqrt_fp_iter.sv - directed self-checking bench for sqrt_fp_iter
module tb_sqrt_fp_iter;

  logic        clk;
  logic        rst;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] in_a32, out_sqrt32;
  logic        out_inv32, out_inex32;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] in_a16, out_sqrt16;
  logic        out_inv16, out_inex16;

  int checks;
  int failures;

  sqrt_fp_iter #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid32),
    .in_ready    (in_ready32),
    .in_a        (in_a32),
    .out_valid   (out_valid32),
    .out_ready   (out_ready32),
    .out_sqrt    (out_sqrt32),
    .out_invalid (out_inv32),
    .out_inexact (out_inex32)
  );

  sqrt_fp_iter #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid16),
    .in_ready    (in_ready16),
    .in_a        (in_a16),
    .out_valid   (out_valid16),
    .out_ready   (out_ready16),
    .out_sqrt    (out_sqrt16),
    .out_invalid (out_inv16),
    .out_inexact (out_inex16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand, release it after the accepting edge, scramble in_a,
  // then count edges after the accept until out_valid (0 = valid right after accept)
  task automatic xact32(input logic [31:0] a, output logic [31:0] res,
                        output logic inv, output logic inex, output int lat);
    @(negedge clk);
    in_a32      = a;
    in_valid32  = 1'b1;
    out_ready32 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid32 = 1'b0;
    in_a32     = 32'hDEAD_BEEF;
    lat = 0;
    while (!out_valid32 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid32) lat = -1;
    res  = out_sqrt32;
    inv  = out_inv32;
    inex = out_inex32;
  endtask

  task automatic release32(output logic ov, output logic ir);
    @(negedge clk);
    out_ready32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready32 = 1'b0;
    ov = out_valid32;
    ir = in_ready32;
  endtask

  task automatic xact16(input logic [15:0] a, output logic [15:0] res,
                        output logic inv, output logic inex, output int lat);
    @(negedge clk);
    in_a16      = a;
    in_valid16  = 1'b1;
    out_ready16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    in_a16     = 16'hBEEF;
    lat = 0;
    while (!out_valid16 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid16) lat = -1;
    res  = out_sqrt16;
    inv  = out_inv16;
    inex = out_inex16;
    @(negedge clk);
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid32 = 1'b0; in_a32 = '0; out_ready32 = 1'b0;
    in_valid16 = 1'b0; in_a16 = '0; out_ready16 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid32 !== 1'b0 || out_sqrt32 !== 32'h0 || out_inv32 !== 1'b0 || out_inex32 !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b sqrt=%h inv=%b inex=%b, required 0 00000000 0 0",
               out_valid32, out_sqrt32, out_inv32, out_inex32);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready32 !== 1'b1 || in_ready16 !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b/%b, required 1/1", in_ready32, in_ready16);
    end
  endtask

  task automatic test_normal32();
    logic [31:0] res; logic inv, inex, ov, ir; int lat;
    xact32(32'h4080_0000, res, inv, inex, lat);
    checks++;
    if (lat !== 26) begin failures++; $display("FAIL lat_4p0: got %0d, required 26", lat); end
    checks++;
    if (res !== 32'h4000_0000) begin failures++; $display("FAIL sqrt_4p0: got %h, required 40000000", res); end
    checks++;
    if (inex !== 1'b0 || inv !== 1'b0) begin failures++; $display("FAIL flags_4p0: got inv=%b inex=%b, required 0 0", inv, inex); end
    release32(ov, ir);
    checks++;
    if (ov !== 1'b0 || ir !== 1'b1) begin failures++; $display("FAIL release_4p0: got valid=%b ready=%b, required 0 1", ov, ir); end
    xact32(32'h3E80_0000, res, inv, inex, lat);
    checks++;
    if (res !== 32'h3F00_0000 || inex !== 1'b0) begin
      failures++; $display("FAIL sqrt_0p25: got %h inex=%b, required 3f000000 0", res, inex);
    end
    release32(ov, ir);
  endtask

  task automatic test_inexact32();
    logic [31:0] res; logic inv, inex, ov, ir; int lat;
    xact32(32'h4000_0000, res, inv, inex, lat);
    checks++;
    if (res !== 32'h3FB5_04F3) begin failures++; $display("FAIL sqrt_2p0: got %h, required 3fb504f3", res); end
    checks++;
    if (inex !== 1'b1 || inv !== 1'b0) begin failures++; $display("FAIL flags_2p0: got inv=%b inex=%b, required 0 1", inv, inex); end
    release32(ov, ir);
  endtask

  task automatic test_specials();
    logic [31:0] ops [5] = '{32'hC080_0000, 32'h8000_0000, 32'h7F80_0000, 32'h0000_0001, 32'h7F80_0001};
    logic [31:0] exp [5] = '{32'h7FC0_0000, 32'h8000_0000, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000};
    logic        einv [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] res; logic inv, inex, ov, ir; int lat;
    for (int i = 0; i < 5; i++) begin
      xact32(ops[i], res, inv, inex, lat);
      checks++;
      if (lat !== 0) begin failures++; $display("FAIL special_lat[%0d]: got %0d, required 0", i, lat); end
      checks++;
      if (res !== exp[i] || inv !== einv[i] || inex !== 1'b0) begin
        failures++;
        $display("FAIL special[%0d] op=%h: got %h inv=%b inex=%b, required %h inv=%b inex=0",
                 i, ops[i], res, inv, inex, exp[i], einv[i]);
      end
      release32(ov, ir);
      checks++;
      if (ov !== 1'b0) begin failures++; $display("FAIL special_release[%0d]: valid=%b, required 0", i, ov); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res; logic inv, inex; int lat;
    xact32(32'h4000_0000, res, inv, inex, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid32 !== 1'b1 || out_sqrt32 !== 32'h3FB5_04F3 || in_ready32 !== 1'b0 || out_inex32 !== 1'b1) begin
        failures++;
        $display("FAIL hold[%0d]: valid=%b sqrt=%h ready=%b inex=%b, required 1 3fb504f3 0 1",
                 i, out_valid32, out_sqrt32, in_ready32, out_inex32);
      end
    end
    // Offer the next operand on the same edge that drains the result
    @(negedge clk);
    out_ready32 = 1'b1;
    in_valid32  = 1'b1;
    in_a32      = 32'h4080_0000;
    @(posedge clk);
    @(negedge clk);
    out_ready32 = 1'b0;
    checks++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
      failures++; $display("FAIL drain_edge: valid=%b ready=%b, required 0 1", out_valid32, in_ready32);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid32 = 1'b0;
    lat = 0;
    while (!out_valid32 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat !== 26 || out_sqrt32 !== 32'h4000_0000) begin
      failures++; $display("FAIL after_drain: lat=%0d sqrt=%h, required 26 40000000", lat, out_sqrt32);
    end
    @(negedge clk);
    out_ready32 = 1'b1;
    @(negedge clk);
    out_ready32 = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [31:0] res; logic inv, inex, ov, ir; int lat;
    // Leave a result with the invalid flag set in the output registers
    xact32(32'hC080_0000, res, inv, inex, lat);
    release32(ov, ir);
    @(negedge clk);
    in_a32     = 32'h4080_0000;
    in_valid32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid32 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid32 !== 1'b0 || out_inv32 !== 1'b0 || out_inex32 !== 1'b0 || out_sqrt32 !== 32'h0) begin
      failures++;
      $display("FAIL midop_reset: valid=%b inv=%b inex=%b sqrt=%h, required 0 0 0 00000000",
               out_valid32, out_inv32, out_inex32, out_sqrt32);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0) begin
      failures++; $display("FAIL midop_ready: ready=%b valid=%b, required 1 0", in_ready32, out_valid32);
    end
    xact32(32'h4080_0000, res, inv, inex, lat);
    checks++;
    if (lat !== 26 || res !== 32'h4000_0000) begin
      failures++; $display("FAIL midop_fresh: lat=%0d sqrt=%h, required 26 40000000", lat, res);
    end
    release32(ov, ir);
  endtask

  task automatic test_fp16();
    logic [15:0] res; logic inv, inex; int lat;
    xact16(16'h4880, res, inv, inex, lat);
    checks++;
    if (lat !== 13) begin failures++; $display("FAIL fp16_lat_9p0: got %0d, required 13", lat); end
    checks++;
    if (res !== 16'h4200 || inex !== 1'b0 || inv !== 1'b0) begin
      failures++; $display("FAIL fp16_sqrt_9p0: got %h inv=%b inex=%b, required 4200 0 0", res, inv, inex);
    end
    xact16(16'h4400, res, inv, inex, lat);
    checks++;
    if (res !== 16'h4000 || inex !== 1'b0) begin
      failures++; $display("FAIL fp16_sqrt_4p0: got %h inex=%b, required 4000 0", res, inex);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_normal32();
    test_inexact32();
    test_specials();
    test_backpressure();
    test_reset_midop();
    test_fp16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
